regfile_wb_sched: RTL

- Write-back scheduler and scoreboard for the 8 x 16-bit register file.
- The register file has a single write port. This block shares it between NUM_REQ write-back sources (e.g. ALU, load unit) with valid/ready handshakes and round-robin arbitration.
- Drives the register file's Reg_Write, Reg_address3 and Reg_input_data inputs from registered outputs.
- Keeps an 8-bit busy scoreboard. Issue logic uses it for RAW hazard detection and WAW stalls.

---
 rtl/regfile_wb_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// ---------------------------------------------------------------------------
// regfile_wb_sched
//
// Write-back scheduler and busy scoreboard for the 8 x 16-bit register file.
// The register file has one write port. NUM_REQ write-back sources share it
// through valid/ready handshakes. The port drives the register file from
// registered outputs, so a granted write commits one cycle after its grant.
// An 8-bit busy scoreboard tracks outstanding destination writes. The issue
// stage uses it to detect RAW hazards and to stall on WAW.
//
// Parameters:
//   NUM_REQ  number of write-back requesters (2..4)
//   DATA_W   write data width; must match the register file
//   ADDR_W   register address width (8 registers)
//
// Ports:
//   CLK             rising-edge clock
//   Reset           synchronous active-low reset
//   Req_valid       per-requester write pending
//   Req_addr        per-requester destination, slice i at [ADDR_W*i +: ADDR_W]
//   Req_data        per-requester data, slice i at [DATA_W*i +: DATA_W]
//   Req_ready       one-hot combinational grant
//   Mark_valid      issue stage reserves Mark_addr
//   Mark_addr       register being reserved
//   Mark_ready      reservation accepted (register not busy)
//   Src1/2_addr     source operands of the instruction in issue
//   Src1/2_used     operand is actually read
//   Hazard          a used source operand is busy
//   Busy            scoreboard; bit r set while a write to r is outstanding
//   Reg_Write       register file write enable (registered)
//   Reg_address3    register file write address (registered)
//   Reg_input_data  register file write data (registered)
//
// Build option:
//   WB_SCHED_FIXED_PRIO_EN  when defined, the lowest index always wins and
//                           the round-robin pointer is removed. The default
//                           build arbitrates round-robin.
// ---------------------------------------------------------------------------
module regfile_wb_sched #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3
) (
   input  logic                      CLK,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        Req_valid,
   input  logic [ADDR_W*NUM_REQ-1:0] Req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] Req_data,
   output logic [NUM_REQ-1:0]        Req_ready,
   input  logic                      Mark_valid,
   input  logic [ADDR_W-1:0]         Mark_addr,
   output logic                      Mark_ready,
   input  logic [ADDR_W-1:0]         Src1_addr,
   input  logic [ADDR_W-1:0]         Src2_addr,
   input  logic                      Src1_used,
   input  logic                      Src2_used,
   output logic                      Hazard,
   output logic [(1<<ADDR_W)-1:0]    Busy,
   output logic                      Reg_Write,
   output logic [ADDR_W-1:0]         Reg_address3,
   output logic [DATA_W-1:0]         Reg_input_data
);

   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]  grant;
   logic                xfer;
   logic [ADDR_W-1:0]   grant_addr;
   logic [DATA_W-1:0]   grant_data;
   logic [NUM_REGS-1:0] busy_set;
   logic [NUM_REGS-1:0] busy_clr;
`ifndef WB_SCHED_FIXED_PRIO_EN
   logic [PTR_W-1:0]    grant_idx;
   logic [PTR_W-1:0]    rr_ptr;
`endif

   // Arbiter: walk the requesters starting at the pointer. Under the fixed
   // priority build, the walk starts at index 0. The first valid index wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      logic             found;
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a value unassigned and no latch is inferred.
      grant = '0;
      found = 1'b0;
      idx   = '0;
`ifndef WB_SCHED_FIXED_PRIO_EN
      grant_idx = '0;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_SCHED_FIXED_PRIO_EN
         idx = PTR_W'(k);
`else
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
`endif
         if (!found && Req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
`ifndef WB_SCHED_FIXED_PRIO_EN
            grant_idx  = idx;
`endif
         end
      end
      // No handshake can complete while reset is held.
      if (!Reset) begin
         grant = '0;
      end
   end

   // The grant is one-hot, so a plain select of the winning slice suffices.
   always_comb begin
      grant_addr = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_addr = Req_addr[ADDR_W*i +: ADDR_W];
            grant_data = Req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   assign xfer      = |grant;
   assign Req_ready = grant;

   // No bypass: a register stays busy until the edge where its data is
   // written. A read in the next cycle therefore sees the committed value.
   assign Mark_ready = Reset & ~Busy[Mark_addr];
   assign Hazard     = (Src1_used & Busy[Src1_addr]) | (Src2_used & Busy[Src2_addr]);

   // A set and a clear never hit the same bit at one edge, because
   // Mark_ready is low while the bit is busy.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (Mark_valid && Mark_ready) begin
         busy_set[Mark_addr] = 1'b1;
      end
      if (Reg_Write) begin
         busy_clr[Reg_address3] = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         Busy           <= '0;
         Reg_Write      <= 1'b0;
         Reg_address3   <= '0;
         Reg_input_data <= '0;
      end else begin
         Busy      <= (Busy & ~busy_clr) | busy_set;
         Reg_Write <= xfer;
         // Address and data hold between writes. Only the enable pulses.
         if (xfer) begin
            Reg_address3   <= grant_addr;
            Reg_input_data <= grant_data;
         end
      end
   end

`ifndef WB_SCHED_FIXED_PRIO_EN
   // The pointer moves one past the winner, so the winner drops to lowest
   // priority on the next arbitration.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
      end
   end
`endif

endmodule
